// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for pipe_ctrl (stop flags, stall levels, FSM states, stall masks)
package pipe_ctrl_pkg;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;
  typedef enum logic [2:0] {STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM} stall_lvl_e;
  typedef enum logic [1:0] {PC_RUN, PC_PEND, PC_DROP} pc_state_e;
  localparam logic [5:0] STALL_MASK_NONE = {6{NoStop}};
  localparam logic [5:0] STALL_MASK_IF   = {{4{NoStop}}, {2{Stop}}};
  localparam logic [5:0] STALL_MASK_ID   = {{3{NoStop}}, {3{Stop}}};
  localparam logic [5:0] STALL_MASK_EX   = {{2{NoStop}}, {4{Stop}}};
  localparam logic [5:0] STALL_MASK_MEM  = {NoStop, {5{Stop}}};
  function automatic logic [5:0] stall_mask(stall_lvl_e l);
    return l == STALL_MEM ? STALL_MASK_MEM :
           l == STALL_EX  ? STALL_MASK_EX  :
           l == STALL_ID  ? STALL_MASK_ID  :
           l == STALL_IF  ? STALL_MASK_IF  : STALL_MASK_NONE;
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline <-> sequencing controller bundle
// master: pipeline side (drives stall requests and EX branch resolution)
// slave : pipe_ctrl (drives stall vector, redirect, flushes, fetch drop)
interface pipe_ctrl_if #(parameter int ADDR_W = 32);
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              ex_branch_i;
  logic [ADDR_W-1:0] ex_target_i;
  logic [5:0]        stall;
  logic              redirect_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              if_idflush_o;
  logic              id_exflush_o;
  logic              if_drop_o;
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, ex_branch_i, ex_target_i,
    input  stall, redirect_o, redirect_pc_o, if_idflush_o, id_exflush_o, if_drop_o
  );
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, ex_branch_i, ex_target_i,
    output stall, redirect_o, redirect_pc_o, if_idflush_o, id_exflush_o, if_drop_o
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: wrapping 32-bit counters of winning stall level per cycle and of redirects
// in : clk, rst, lvl (winning stall level), redirect
// out: perf_stall_if/id/ex/mem, perf_flush
module pipe_perf_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  stall_lvl_e  lvl,
  input  logic        redirect,
  output logic [31:0] perf_stall_if,
  output logic [31:0] perf_stall_id,
  output logic [31:0] perf_stall_ex,
  output logic [31:0] perf_stall_mem,
  output logic [31:0] perf_flush
);
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_if  <= '0;
      perf_stall_id  <= '0;
      perf_stall_ex  <= '0;
      perf_stall_mem <= '0;
      perf_flush     <= '0;
    end else begin
      perf_stall_if  <= perf_stall_if  + 32'(lvl == STALL_IF);
      perf_stall_id  <= perf_stall_id  + 32'(lvl == STALL_ID);
      perf_stall_ex  <= perf_stall_ex  + 32'(lvl == STALL_EX);
      perf_stall_mem <= perf_stall_mem + 32'(lvl == STALL_MEM);
      perf_flush     <= perf_flush     + 32'(redirect);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline sequencer (stall merge, branch redirect/flush, deferred redirect, stale fetch drop)
// ports: clk, rst (sync, active-high), bus (pipe_ctrl_if.slave: stall requests, EX branch in;
//        stall vector, redirect, flushes, fetch drop out)
// PIPE_PERF_CNT_EN: adds perf_stall_if/id/ex/mem and perf_flush counter outputs
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_if,
  output logic [31:0] perf_stall_id,
  output logic [31:0] perf_stall_ex,
  output logic [31:0] perf_stall_mem,
  output logic [31:0] perf_flush
`endif
);
  stall_lvl_e        lvl;
  pc_state_e         state, state_nx;
  logic [ADDR_W-1:0] pend_pc;
  logic [5:0]        mask;
  logic              fire, defer;
  always_comb
    lvl = bus.stallreq_mem ? STALL_MEM :
          bus.stallreq_ex  ? STALL_EX  :
          bus.stallreq_id  ? STALL_ID  :
          bus.stallreq_if  ? STALL_IF  : STALL_NONE;
  // PEND ignores ex_branch_i: a frozen EX cannot present a new branch
  assign fire  = (state == PC_PEND || bus.ex_branch_i) && lvl <= STALL_ID;
  assign defer = state != PC_PEND && bus.ex_branch_i && lvl >= STALL_EX;
  always_ff @(posedge clk)
    state <= rst ? PC_RUN : state_nx;
  always_ff @(posedge clk)
    if (rst) pend_pc <= '0;
    else if (defer) pend_pc <= bus.ex_target_i;
  // a fetch still in flight across a redirect (or in DROP) must be discarded when it returns
  always_comb
    state_nx = defer                      ? PC_PEND :
               fire || state == PC_DROP   ? (bus.stallreq_if ? PC_DROP : PC_RUN) : state;
  always_comb begin
    mask              = stall_mask(lvl);
    bus.stall         = {NoStop, mask[4:3], fire ? {3{NoStop}} : mask[2:0]};
    bus.redirect_o    = fire;
    bus.redirect_pc_o = fire ? (state == PC_PEND ? pend_pc : bus.ex_target_i) : '0;
    bus.if_idflush_o  = fire;
    bus.id_exflush_o  = fire;
    bus.if_drop_o     = state == PC_DROP;
  end
`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt u_perf (
    .clk            (clk),
    .rst            (rst),
    .lvl            (lvl),
    .redirect       (fire),
    .perf_stall_if  (perf_stall_if),
    .perf_stall_id  (perf_stall_id),
    .perf_stall_ex  (perf_stall_ex),
    .perf_stall_mem (perf_stall_mem),
    .perf_flush     (perf_flush)
  );
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  pipe_ctrl_if #(.ADDR_W(32)) bus ();
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_if, perf_stall_id, perf_stall_ex, perf_stall_mem, perf_flush;
  logic [31:0] base_ex, base_flush, base_mem;
`endif
  pipe_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_if  (perf_stall_if),
    .perf_stall_id  (perf_stall_id),
    .perf_stall_ex  (perf_stall_ex),
    .perf_stall_mem (perf_stall_mem),
    .perf_flush     (perf_flush)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string t, input logic [5:0] s, input logic r, input logic [31:0] pc, input logic drop);
    check({t, ".stall"}, 64'(bus.stall), 64'(s));
    check({t, ".redirect"}, 64'(bus.redirect_o), 64'(r));
    check({t, ".pc"}, 64'(bus.redirect_pc_o), 64'(pc));
    check({t, ".ifid_flush"}, 64'(bus.if_idflush_o), 64'(r));
    check({t, ".idex_flush"}, 64'(bus.id_exflush_o), 64'(r));
    check({t, ".drop"}, 64'(bus.if_drop_o), 64'(drop));
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic fi, input logic di, input logic ex, input logic mem, input logic br, input logic [31:0] tgt);
    bus.stallreq_if  = fi;
    bus.stallreq_id  = di;
    bus.stallreq_ex  = ex;
    bus.stallreq_mem = mem;
    bus.ex_branch_i  = br;
    bus.ex_target_i  = tgt;
    #3;
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 32'h0);
    cyc();
    cyc();
    chk_all("reset", 6'b000000, 0, 32'h0, 0);
    rst = 1'b0;
    cyc(); set(0, 1, 0, 0, 0, 32'h0);   chk_all("id_only", 6'b000111, 0, 32'h0, 0);
    cyc(); set(0, 0, 0, 1, 0, 32'h0);   chk_all("mem_only", 6'b011111, 0, 32'h0, 0);
    cyc(); set(1, 0, 0, 0, 0, 32'h0);   chk_all("if_only", 6'b000011, 0, 32'h0, 0);
    cyc(); set(1, 1, 1, 0, 0, 32'h0);   chk_all("ex_wins", 6'b001111, 0, 32'h0, 0);
    cyc(); set(0, 0, 0, 0, 1, 32'h100); chk_all("br_run", 6'b000000, 1, 32'h100, 0);
    cyc(); set(0, 0, 0, 0, 0, 32'h100); chk_all("br_run_after", 6'b000000, 0, 32'h0, 0);
    cyc(); set(0, 1, 0, 0, 1, 32'h180); chk_all("br_id", 6'b000000, 1, 32'h180, 0);
    cyc(); set(0, 0, 0, 1, 1, 32'h2A0); chk_all("defer_c1", 6'b011111, 0, 32'h0, 0);
    cyc(); set(0, 0, 0, 1, 1, 32'h999); chk_all("defer_c2", 6'b011111, 0, 32'h0, 0);
    cyc(); set(0, 0, 0, 1, 0, 32'h0);   chk_all("defer_c3", 6'b011111, 0, 32'h0, 0);
    cyc(); set(0, 0, 0, 0, 0, 32'h555); chk_all("defer_fire", 6'b000000, 1, 32'h2A0, 0);
    cyc(); set(0, 0, 0, 0, 0, 32'h0);   chk_all("defer_after", 6'b000000, 0, 32'h0, 0);
    cyc(); set(0, 0, 1, 0, 1, 32'h500); chk_all("ex_defer", 6'b001111, 0, 32'h0, 0);
    cyc(); set(0, 0, 0, 0, 0, 32'h0);   chk_all("ex_min_defer", 6'b000000, 1, 32'h500, 0);
    cyc(); set(1, 0, 0, 0, 1, 32'h300); chk_all("fetch_br", 6'b000000, 1, 32'h300, 0);
    cyc(); set(1, 0, 0, 0, 0, 32'h0);   chk_all("drop_c1", 6'b000011, 0, 32'h0, 1);
    cyc(); set(1, 0, 0, 0, 0, 32'h0);   chk_all("drop_c2", 6'b000011, 0, 32'h0, 1);
    cyc(); set(0, 0, 0, 0, 0, 32'h0);   chk_all("drop_fall", 6'b000000, 0, 32'h0, 1);
    cyc(); set(0, 0, 0, 0, 0, 32'h0);   chk_all("drop_done", 6'b000000, 0, 32'h0, 0);
    cyc(); set(0, 0, 1, 0, 1, 32'h40);  chk_all("pend_enter", 6'b001111, 0, 32'h0, 0);
    cyc(); rst = 1'b1; set(0, 0, 1, 0, 0, 32'h0); chk_all("pend_rst", 6'b001111, 0, 32'h0, 0);
    cyc(); rst = 1'b0; set(0, 0, 0, 0, 0, 32'h0); chk_all("pend_rst_c1", 6'b000000, 0, 32'h0, 0);
    cyc(); set(0, 0, 0, 0, 0, 32'h0);   chk_all("pend_rst_c2", 6'b000000, 0, 32'h0, 0);
`ifdef PIPE_PERF_CNT_EN
    base_ex    = perf_stall_ex;
    base_flush = perf_flush;
    base_mem   = perf_stall_mem;
    for (int i = 0; i < 5; i++) begin
      cyc(); set(0, 0, 1, 0, 0, 32'h0);
    end
    cyc(); set(0, 0, 0, 0, 1, 32'h700);
    cyc(); set(0, 0, 0, 0, 1, 32'h704);
    cyc(); set(0, 0, 0, 0, 0, 32'h0);
    check("perf_stall_ex", 64'(perf_stall_ex - base_ex), 64'd5);
    check("perf_flush", 64'(perf_flush - base_flush), 64'd2);
    check("perf_stall_mem", 64'(perf_stall_mem - base_mem), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
